id_char_tx: RTL
===============

// Module: id_char_tx
// PURPOSE
//   Transmit side of the identifier character stream. Accepts a packed string
//   of up to MAX_LEN ASCII chars and emits it one char per transfer over a
//   valid/ready link, then emits a terminator char. Runs a mirror of the
//   identifier classifier (letter/digit/other) on the transmitted chars.
//   At end of string it reports whether that classifier ends "after number"
//   (letter-led run whose last char is a digit), so the bench can check the
//   downstream recognizer.
// PARAMETERS
//   MAX_LEN  8      max chars per string; LW = $clog2(MAX_LEN+1)
//   TERM     8'h20  terminator char sent after the last data char (must be non-alphanumeric)
// PORTS
//   clk         in   1          rising-edge clock
//   rst_n       in   1          synchronous reset, active-low
//   load_valid  in   1          load request
//   load_ready  out  1          1 only in IDLE; load transfers when valid&&ready
//   load_len    in   LW         number of chars; values > MAX_LEN are clamped to MAX_LEN
//   load_data   in   8*MAX_LEN  char k in bits [8k+7:8k]; char 0 is sent first
//   char_out    out  8          current char
//   char_valid  out  1          char_out valid
//   char_ready  in   1          sink accepts; char transfers when valid&&ready
//   busy        out  1          string in flight (SEND or TERM)
//   done        out  1          1-cycle pulse after the terminator transfers
//   end_num     out  1          classifier state before the terminator == AFTER_NUMBER; valid with done, held until next load
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     state=IDLE; char_valid=0; char_out=0; done=0; end_num=0; busy=0.
//     Classifier = AFTER_OTHER. Applies mid-string too: the string is dropped
//     with no terminator and no done.
//   FSM: IDLE -> SEND -> TERM -> IDLE.
//     IDLE:
//       load_ready=1.
//       On load: latch data and len (clamped); idx=0; classifier=AFTER_OTHER.
//       len>0 -> SEND, else -> TERM.
//       char_valid rises the cycle after load (1-cycle latency).
//     SEND:
//       char_out=data[idx]; char_valid=1.
//       On transfer: classifier updates with char_out; idx++.
//       idx==len-1 at transfer -> TERM.
//     TERM:
//       char_out=TERM; char_valid=1.
//       On transfer: end_num <= (classifier==AFTER_NUMBER); done=1 next
//       cycle; -> IDLE.
//   Handshake rules:
//     While char_valid && !char_ready, char_out is held stable and does not
//     advance.
//     Back-to-back transfers sustain one char per cycle.
//     load_ready is 0 in SEND and TERM. A new load is accepted no earlier
//     than the cycle done is high, since the FSM is already back in IDLE then.
//   Classifier transitions:
//     letter = a-z, A-Z; digit = 0-9; anything else = other.
//     From OTHER:  letter -> LETTER; else -> OTHER.
//     From LETTER: digit -> NUMBER; letter -> LETTER; else -> OTHER.
//     From NUMBER: digit -> NUMBER; letter -> LETTER; else -> OTHER.
//     Digits never leave OTHER.
//   Index: idx is LW bits and never exceeds len-1; no wrap.
//   Chars beyond len in load_data are ignored.
// TESTING
//   1. load "a1" (len=2), char_ready=1 -> char_out 'a','1',8'h20 on 3 consecutive cycles; done pulse; end_num=1
//   2. load "ab" -> end_num=0; load "12" -> end_num=0 (digits from OTHER stay OTHER)
//   3. load "x9" with char_ready low 3 cycles on 'x' -> 'x' held stable 3 cycles; total 3 transfers; end_num=1
//   4. load_len=0 -> only 8'h20 sent, done, end_num=0; load_len=15 with MAX_LEN=8 -> exactly 8 chars then terminator
//   5. rst_n=0 after 2nd char of 4 -> next cycle char_valid=0, load_ready=1, no done; new load "q7" -> end_num=1
//   6. load_valid held in SEND -> not accepted until IDLE; accepted the cycle done is high

Source files
------------

// File: rtl/id_char_tx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// id_char_tx
//   Transmit side of the identifier character stream. A packed string of up
//   to MAX_LEN ASCII chars is loaded, sent one char per valid/ready transfer
//   (char 0 first), and followed by the TERM char. A letter/digit/other
//   classifier tracks the sent chars; when the terminator transfers, end_num
//   reports whether the string ended on a letter-led run ending in a digit.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   load_valid  load request
//   load_ready  high only in IDLE; load happens on load_valid && load_ready
//   load_len    char count (LW bits), clamped to MAX_LEN
//   load_data   char k in bits [8k+7:8k]
//   char_out    current char
//   char_valid  char_out valid
//   char_ready  sink accepts; char moves on char_valid && char_ready
//   busy        string in flight (SEND or TERM)
//   done        one-cycle pulse after the terminator transfers
//   end_num     classifier was AFTER_NUMBER before the terminator; valid with
//               done, held until the next load
// ----------------------------------------------------------------------------
module id_char_tx #(
   parameter int         MAX_LEN = 8,
   parameter logic [7:0] TERM    = 8'h20,
   localparam int        LW      = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [LW-1:0]        load_len,
   input  logic [8*MAX_LEN-1:0] load_data,
   output logic [7:0]           char_out,
   output logic                 char_valid,
   input  logic                 char_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 end_num
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_TERM} state_e;
   typedef enum logic [1:0] {C_OTHER, C_LETTER, C_NUMBER} cls_e;

   state_e        state_q, state_d;
   cls_e          cls_q, cls_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [LW-1:0] len_q, len_clamped;
   logic [7:0]    data_q [MAX_LEN];
   logic          done_q, done_d;
   logic          end_num_q, end_num_d;
   logic [7:0]    sel_char;
   logic          load_fire;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= 8'h61) && (c <= 8'h7a)) || ((c >= 8'h41) && (c <= 8'h5a));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Digits only extend a run that a letter started; from OTHER they stay OTHER.
   function automatic cls_e cls_next(input cls_e cur, input logic [7:0] c);
      cls_e nxt;
      nxt = C_OTHER;
      if (is_letter(c)) begin
         nxt = C_LETTER;
      end else if (is_digit(c) && (cur != C_OTHER)) begin
         nxt = C_NUMBER;
      end
      return nxt;
   endfunction

   assign load_ready  = (state_q == S_IDLE);
   assign char_valid  = (state_q != S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign end_num     = end_num_q;
   assign load_fire   = load_valid && load_ready;
   assign len_clamped = (load_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : load_len;

   // Mux by comparison so the LW-bit index never has to match the array width.
   always_comb begin
      sel_char = 8'h00;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (idx_q == LW'(k)) begin
            sel_char = data_q[k];
         end
      end
   end

   always_comb begin
      char_out = 8'h00;
      case (state_q)
         S_SEND:  char_out = sel_char;
         S_TERM:  char_out = TERM;
         default: char_out = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      end_num_d = end_num_q;
      case (state_q)
         S_IDLE: begin
            if (load_valid) begin
               idx_d     = '0;
               cls_d     = C_OTHER;
               end_num_d = 1'b0;
               state_d   = (len_clamped == '0) ? S_TERM : S_SEND;
            end
         end
         S_SEND: begin
            if (char_ready) begin
               cls_d = cls_next(cls_q, sel_char);
               if (idx_q == len_q - LW'(1)) begin
                  state_d = S_TERM;
               end else begin
                  idx_d = idx_q + LW'(1);
               end
            end
         end
         S_TERM: begin
            if (char_ready) begin
               end_num_d = (cls_q == C_NUMBER);
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= C_OTHER;
         idx_q     <= '0;
         done_q    <= 1'b0;
         end_num_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         end_num_q <= end_num_d;
      end
   end

   // String payload is only meaningful after a load, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         len_q <= len_clamped;
         for (int k = 0; k < MAX_LEN; k++) begin
            data_q[k] <= load_data[8*k +: 8];
         end
      end
   end

endmodule
